// File: rtl/ram_copy_ctrl.sv
// ram_copy_ctrl: copies a block of words within a synchronous single-port RAM, one read-write pair at a time
module ram_copy_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, WT, WR, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] src, dst;
  logic [ADDR_W:0] len, wd_inc;
  assign wd_inc = words_done + (ADDR_W+1)'(1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state: three cycles per word, a zero-length copy goes straight to DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? (length != '0 ? RD : DONE) : IDLE;
      RD:   state_nx = WT;
      WT:   state_nx = WR;
      WR:   state_nx = wd_inc < len ? RD : DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Operand latch and RAM port registers; addresses wrap modulo the RAM size
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      src <= '0;
      dst <= '0;
      len <= '0;
      words_done <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src <= src_addr;
          dst <= dst_addr;
          len <= length;
          words_done <= '0;
          mem_we <= 1'b0;
          if (length != '0) mem_addr <= src_addr;
        end
        WT: begin
          mem_wdata <= mem_rdata;
          mem_addr <= dst + words_done[ADDR_W-1:0];
          mem_we <= 1'b1;
        end
        WR: begin
          mem_we <= 1'b0;
          words_done <= wd_inc;
          if (wd_inc < len) mem_addr <= src + wd_inc[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_ram_copy_ctrl.sv
// tb_ram_copy_ctrl: scoreboard bench with a behavioural synchronous RAM and a sequential-copy reference model
module tb_ram_copy_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [AW:0] length = '0;
  logic busy, done, mem_we;
  logic [AW:0] words_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] ram [32];
  logic [DW-1:0] ram_m [32];
  wr_t exp_q[$];
  int errors = 0, checks = 0, writes = 0;

  always #5 clk = ~clk;

  ram_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .words_done(words_done), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Behavioural RAM: synchronous read, write on the same edge
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write the DUT presents is popped from the scoreboard and compared
  always @(negedge clk)
    if (mem_we) begin
      writes++;
      chk("write_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(mem_addr), 64'(e.a));
        chk("write_data", 64'(mem_wdata), 64'(e.d));
      end
    end

  // Reference: sequential ascending copy, pushing the first nw writes
  task automatic model(input int src, input int dst, input int len, input int nw);
    for (int i = 0; i < len && i < nw; i++) begin
      wr_t e;
      e.a = AW'((dst + i) % 32);
      e.d = ram_m[(src + i) % 32];
      ram_m[e.a] = e.d;
      exp_q.push_back(e);
    end
  endtask

  task automatic ram_cmp(input string tag);
    int bad = 0;
    for (int i = 0; i < 32; i++) if (ram[i] !== ram_m[i]) bad++;
    chk(tag, 64'(bad), 0);
  endtask

  task automatic drive(input int src, input int dst, input int len);
    start = 1;
    src_addr = AW'(src);
    dst_addr = AW'(dst);
    length = (AW+1)'(len);
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic copy(input string tag, input int src, input int dst, input int len, input bit mid, input bit at_neg);
    int lat = 0, w0;
    model(src, dst, len, len);
    w0 = writes;
    if (!at_neg) @(negedge clk);
    drive(src, dst, len);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = mid && k == 5;
      if (start) begin
        src_addr = 10;
        dst_addr = 25;
        length = 5;
      end
      if (k == 2) chk({tag, "_busy"}, 64'(busy), 1);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 0;
    chk({tag, "_latency"}, 64'(lat), 64'(len == 0 ? 1 : 3 * len + 1));
    chk({tag, "_words_done"}, 64'(words_done), 64'(len));
    @(negedge clk);
    chk({tag, "_idle"}, 64'({busy, done}), 0);
    chk({tag, "_writes"}, 64'(writes - w0), 64'(len));
    chk({tag, "_queue"}, 64'(exp_q.size()), 0);
    ram_cmp({tag, "_ram"});
  endtask

  initial begin
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_we", 64'(mem_we), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_wdata", 64'(mem_wdata), 0);
    chk("rst_words", 64'(words_done), 0);
    for (int i = 0; i < 32; i++) begin
      ram[i] <= DW'(i + 100);
      ram_m[i] = DW'(i + 100);
    end
    @(negedge clk);
    rst_n = 1;
    copy("basic", 2, 20, 4, 0, 0);
    copy("zero", 5, 9, 0, 0, 0);
    copy("wrap", 30, 5, 3, 0, 0);
    @(negedge clk);
    ram[0] <= 7;
    ram_m[0] = 7;
    copy("overlap", 0, 1, 3, 1, 0);
    copy("long", 3, 10, 34, 0, 0);
    // Abort in WT of the second word: only the first word may land
    model(8, 16, 4, 1);
    @(negedge clk);
    drive(8, 16, 4);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_we", 64'(mem_we), 0);
    chk("abort_pre_words", 64'(words_done), 1);
    rst_n = 0;
    #1;
    chk("abort_we", 64'(mem_we), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_addr", 64'(mem_addr), 0);
    chk("abort_words", 64'(words_done), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 0);
    end
    chk("abort_queue", 64'(exp_q.size()), 0);
    ram_cmp("abort_ram");
    rst_n = 1;
    copy("after_rst", 0, 31, 1, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
